// File: rtl/seq_multiplier_if.sv
// Operand/result bundle between the EX-stage operand path and the iterative multiplier.
// The master side issues requests; the slave side is the multiplier.
interface seq_multiplier_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, signed_op, A, B,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, signed_op, A, B,
    output busy, done, HI, LO
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add MULT/MULTU: one add-and-shift step per clock on operand magnitudes,
// sign fixed up on completion, 2*WIDTH-bit product presented as HI/LO.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_multiplier_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH:0]   acc_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic               neg_res_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;

  logic               load, busy, done, last_step;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     upper;
  logic [2*WIDTH:0]   acc_step;
  logic [2*WIDTH-1:0] product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    last_step  = (count_reg == CW'(WIDTH - 1));
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Multiply magnitudes; -MIN wraps to MIN, which is the right unsigned magnitude.
  always_comb begin
    a_mag    = (bus.signed_op & bus.A[WIDTH-1]) ? -bus.A : bus.A;
    b_mag    = (bus.signed_op & bus.B[WIDTH-1]) ? -bus.B : bus.B;
    upper    = {acc_reg[2*WIDTH], acc_reg[2*WIDTH-1:WIDTH]}
             + (acc_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
    acc_step = {1'b0, upper, acc_reg[WIDTH-1:1]};
    product  = neg_res_reg ? -acc_step[2*WIDTH-1:0] : acc_step[2*WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg   <= '0;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      neg_res_reg <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else if (load) begin
      count_reg   <= '0;
      acc_reg     <= {1'b0, {WIDTH{1'b0}}, b_mag};
      mcand_reg   <= a_mag;
      neg_res_reg <= bus.signed_op & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
    end else if (busy) begin
      count_reg <= count_reg + CW'(1);
      acc_reg   <= acc_step;
      // The final step's sum feeds the result registers directly so HI/LO line up with done.
      if (last_step) begin
        hi_reg <= product[2*WIDTH-1:WIDTH];
        lo_reg <= product[WIDTH-1:0];
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.HI   = hi_reg;
  assign bus.LO   = lo_reg;
endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed vector table, randomized operands
// against an arithmetic reference, and hand-written restart/abort sequences.
module tb_seq_multiplier;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  seq_multiplier_if #(.WIDTH(32)) bus ();

  seq_multiplier #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference product from plain 64-bit arithmetic on sign- or zero-extended operands.
  function automatic logic [63:0] ref_mul(input logic sop, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb;
    xa = sop ? {{32{a[31]}}, a} : {32'b0, a};
    xb = sop ? {{32{b[31]}}, b} : {32'b0, b};
    return xa * xb;
  endfunction

  // busy and done must never overlap
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (bus.busy && bus.done) begin
        errors++;
        $display("FAIL busy_done_overlap got=11 exp=not both");
      end
    end
  end

  task automatic wait_done(input string nm, output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.done) seen = 1'b1;
    end
    chk({nm, "_latency"}, 64'(n), 64'd32);
  endtask

  // Called at a negedge; operands are scrambled right after the load edge.
  task automatic run_op(input string nm, input logic sop, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int n;
    bus.start = 1'b1; bus.signed_op = sop; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom; bus.signed_op = 1'($urandom);
    chk({nm, "_busy"}, 64'(bus.busy), 64'd1);
    wait_done(nm, n);
    chk({nm, "_product"}, {bus.HI, bus.LO}, exp);
    @(negedge clk);
    chk({nm, "_done_pulse"}, {62'b0, bus.done, bus.busy}, 64'd0);
    chk({nm, "_held"}, {bus.HI, bus.LO}, exp);
    $display("op %s sop=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", nm, sop, a, b, bus.HI, bus.LO, n);
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;
    logic        rs;

    vecs[0] = '{"T1",  1'b0, 32'd7,         32'd6,         32'h00000000, 32'h0000002A};
    vecs[1] = '{"T2",  1'b1, 32'hFFFFFFFD,  32'd5,         32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{"T3",  1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 32'h00000001};
    vecs[3] = '{"T3b", 1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000, 32'h00000001};
    vecs[4] = '{"T4",  1'b1, 32'h80000000,  32'h80000000,  32'h40000000, 32'h00000000};
    vecs[5] = '{"T4b", 1'b1, 32'h80000000,  32'd1,         32'hFFFFFFFF, 32'h80000000};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.A = '0; bus.B = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {bus.HI, bus.LO}, 64'd0);
    chk("reset_flags", {62'b0, bus.busy, bus.done}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_flags", {62'b0, bus.busy, bus.done}, 64'd0);

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].name, vecs[i].sop, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0:       ra = 32'h80000000;
        1:       ra = 32'hFFFFFFFF;
        2:       ra = 32'($urandom_range(0, 3));
        default: ra = $urandom;
      endcase
      rb = $urandom;
      rs = 1'($urandom);
      run_op($sformatf("R%0d", i), rs, ra, rb, ref_mul(rs, ra, rb));
    end

    // T5: start during RUN ignored; start in the DONE cycle restarts with old result held
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.A = 32'd3; bus.B = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.start = 1'b1; bus.A = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    chk("T5_busy_ignored", 64'(bus.busy), 64'd1);
    n = 11;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("T5_latency", 64'(n), 64'd32);
    chk("T5_product", {bus.HI, bus.LO}, 64'h0C);
    bus.start = 1'b1; bus.A = 32'd2; bus.B = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    chk("T5_restart_flags", {62'b0, bus.busy, bus.done}, 64'd2);
    chk("T5_old_held", {bus.HI, bus.LO}, 64'h0C);
    wait_done("T5b", n);
    chk("T5b_product", {bus.HI, bus.LO}, 64'd4);
    $display("op T5 3*4 then 2*2 -> hi=%h lo=%h", bus.HI, bus.LO);
    @(negedge clk);

    // T6: asynchronous reset mid-RUN aborts with no done pulse
    bus.start = 1'b1; bus.A = 32'd5; bus.B = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (16) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("T6_abort_flags", {62'b0, bus.busy, bus.done}, 64'd0);
    chk("T6_abort_result", {bus.HI, bus.LO}, 64'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 19) chk("T6_no_done", {62'b0, bus.busy, bus.done}, 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("T6_idle_result", {bus.HI, bus.LO}, 64'd0);
    $display("op T6 abort -> hi=%h lo=%h", bus.HI, bus.LO);
    run_op("T6b", 1'b0, 32'd5, 32'd5, 64'h19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
